// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the K580VT57 four-channel DMA controller.
package k580vt57_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITH,
    ST_S1,
    ST_S2,
    ST_S4
  } state_t;

  // Register select: 0..7 are channel address/count pairs, 8 is mode/status
  localparam logic [3:0] REG_MODE = 4'd8;

  localparam int MB_ROTATE   = 4;
  localparam int MB_EXTWR    = 5;
  localparam int MB_TCSTOP   = 6;
  localparam int MB_AUTOLOAD = 7;

  // Transfer type held in count bits 15:14
  localparam logic [1:0] XM_VERIFY = 2'b00;
  localparam logic [1:0] XM_WRITE  = 2'b01;
  localparam logic [1:0] XM_READ   = 2'b10;

endpackage

// File: rtl/k580vt57_prio.sv
// Rotating-priority encoder: the channel after 'last' has the highest priority.
// Purely combinational; pass last=3 for fixed priority with channel 0 highest.
module k580vt57_prio
  import k580vt57_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [1:0] last,
  output logic [3:0] grant
);

  logic [1:0] idx;

  // Walk from lowest to highest priority so the highest pending one is written last
  always_comb begin
    grant = 4'b0000;
    idx   = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = 2'(int'(last) + i);
      if (pending[idx]) grant = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/k580vt57.sv
// K580VT57 DMA controller; optional channel-2 autoload under K580VT57_AUTOLOAD_EN.
// Latency: hrq one ce cycle after a pending drq, S1 one ce cycle after hlda.
// Backpressure: all progress is gated by ce and hlda; losing hlda ends the transfer early.
module k580vt57
  import k580vt57_pkg::*;
#(
  parameter int DACK_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        memr_n,
  output logic        memw_n,
  output logic        tc,
  output logic        mark
);

`ifdef K580VT57_AUTOLOAD_EN
  localparam int MODE_W = 8;
`else
  localparam int MODE_W = 7;
`endif
  localparam logic [1:0] CYC_LAST = 2'(DACK_CYCLES - 1);

  state_t state, state_nx;
  logic [15:0] addr_r [4];
  logic [15:0] cnt_r  [4];
  logic [MODE_W-1:0] mode;
  logic        ff;
  logic [3:0]  tcflag;
  logic        update;
  logic [1:0]  chan, last, cyc;
  logic        iwe_q, ird_q;

  logic        cpu_wr, cpu_rd, al_en, xfer_tc, reload, s4_upd, active;
  logic [3:0]  addr_hit, cnt_hit, stop_mask, pending, grant;
  logic [1:0]  prio_last, grant_idx, xmode;
  logic [15:0] sel_word;
  logic [13:0] cur_cnt;

  assign cpu_wr = !iwe_q && iwe_n;
  assign cpu_rd = !ird_q && ird_n;

`ifdef K580VT57_AUTOLOAD_EN
  assign al_en = mode[MB_AUTOLOAD];
`else
  assign al_en = 1'b0;
`endif

  assign cur_cnt = cnt_r[chan][13:0];
  assign xmode   = cnt_r[chan][15:14];
  assign xfer_tc = (cur_cnt == 14'd0);
  assign reload  = al_en && (chan == 2'd2) && xfer_tc;
  assign s4_upd  = ce && !reset && (state == ST_S4);
  assign active  = (state == ST_S1) || (state == ST_S2);

  // A TC-stopped channel must not be re-granted by the S4 decision it ends in
  assign stop_mask = (state == ST_S4 && xfer_tc && mode[MB_TCSTOP] && !reload)
                     ? (4'b0001 << chan) : 4'b0000;
  assign pending   = drq & mode[3:0] & ~stop_mask;
  assign prio_last = mode[MB_ROTATE] ? last : 2'd3;

  k580vt57_prio u_prio (
    .pending (pending),
    .last    (prio_last),
    .grant   (grant)
  );

  assign grant_idx = grant[3] ? 2'd3 : grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;

  always_comb begin
    addr_hit = 4'b0000;
    cnt_hit  = 4'b0000;
    if (cpu_wr && !iaddr[3]) begin
      if (iaddr[0]) cnt_hit[iaddr[2:1]]  = 1'b1;
      else          addr_hit[iaddr[2:1]] = 1'b1;
      if (al_en && iaddr[2:1] == 2'd2) begin
        cnt_hit[3]  = cnt_hit[2];
        addr_hit[3] = addr_hit[2];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (|pending) state_nx = ST_WAITH;
      ST_WAITH: if (!(|pending)) state_nx = ST_IDLE;
                else if (hlda) state_nx = ST_S1;
      ST_S1:    state_nx = hlda ? ST_S2 : ST_S4;
      ST_S2:    if (!hlda || cyc == CYC_LAST) state_nx = ST_S4;
      ST_S4:    state_nx = (hlda && |pending) ? ST_S1 : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign hrq    = (state != ST_IDLE);
  assign dack   = active ? (4'b0001 << chan) : 4'b0000;
  assign oaddr  = active ? addr_r[chan] : 16'h0000;
  assign tc     = active && xfer_tc;
  assign mark   = active && (cur_cnt[6:0] == 7'd0) && !xfer_tc;
  assign memr_n = !((state == ST_S2) && (xmode == XM_READ));
  assign memw_n = !((xmode == XM_WRITE) &&
                    ((state == ST_S2) || (state == ST_S1 && mode[MB_EXTWR])));

  always_comb begin
    sel_word = iaddr[0] ? cnt_r[iaddr[2:1]] : addr_r[iaddr[2:1]];
    odata    = 8'h00;
    if (!iaddr[3])              odata = ff ? sel_word[15:8] : sel_word[7:0];
    else if (iaddr == REG_MODE) odata = {3'b000, update, tcflag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode   <= '0;
      ff     <= 1'b0;
      tcflag <= 4'b0000;
      update <= 1'b0;
      chan   <= 2'd0;
      last   <= 2'd3;
      cyc    <= 2'd0;
      iwe_q  <= 1'b1;
      ird_q  <= 1'b1;
    end else begin
      iwe_q <= iwe_n;
      ird_q <= ird_n;
      if (ce) begin
        state <= state_nx;
        cyc   <= (state == ST_S2) ? cyc + 2'd1 : 2'd0;
        if (state_nx == ST_S1 && state != ST_S1) begin
          chan <= grant_idx;
          last <= grant_idx;
        end
      end
      // Clear before set so a TC landing on the status read is not lost
      if (cpu_rd && iaddr == REG_MODE) tcflag <= 4'b0000;
      if (s4_upd && xfer_tc) tcflag[chan] <= 1'b1;
      if (s4_upd) mode[3:0] <= mode[3:0] & ~stop_mask;
      if (cpu_wr && iaddr == REG_MODE) mode <= idata[MODE_W-1:0];
      if (cpu_wr && iaddr == REG_MODE) ff <= 1'b0;
      else if ((cpu_wr || cpu_rd) && !iaddr[3]) ff <= ~ff;
      if (s4_upd && reload) update <= 1'b1;
      else if (ce && state == ST_S1 && chan == 2'd2) update <= 1'b0;
    end
  end

  // Channel registers survive reset; a CPU byte write pre-empts the S4 update
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (addr_hit[k]) begin
        if (ff) addr_r[k][15:8] <= idata;
        else    addr_r[k][7:0]  <= idata;
      end else if (s4_upd && chan == 2'(k)) begin
        addr_r[k] <= reload ? addr_r[3] : addr_r[k] + 16'd1;
      end
      if (cnt_hit[k]) begin
        if (ff) cnt_r[k][15:8] <= idata;
        else    cnt_r[k][7:0]  <= idata;
      end else if (s4_upd && chan == 2'(k)) begin
        cnt_r[k] <= reload ? cnt_r[3] : {cnt_r[k][15:14], cnt_r[k][13:0] - 14'd1};
      end
    end
  end

endmodule

// File: tb/tb_k580vt57.sv
// Scoreboard bench for k580vt57: expected transfers are queued by the stimulus
// and a negedge monitor pops and compares each observed dack transfer.
module tb_k580vt57;

  logic        clk = 1'b0;
  logic        reset, ce, iwe_n, ird_n, hlda;
  logic [3:0]  iaddr, drq, dack;
  logic [7:0]  idata, odata;
  logic        hrq, memr_n, memw_n, tc, mark;
  logic [15:0] oaddr;

  always #5 clk = ~clk;

  k580vt57 #(.DACK_CYCLES(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .iaddr  (iaddr),
    .idata  (idata),
    .odata  (odata),
    .iwe_n  (iwe_n),
    .ird_n  (ird_n),
    .drq    (drq),
    .dack   (dack),
    .hrq    (hrq),
    .hlda   (hlda),
    .oaddr  (oaddr),
    .memr_n (memr_n),
    .memw_n (memw_n),
    .tc     (tc),
    .mark   (mark)
  );

  typedef struct packed {
    logic [3:0]  dack;
    logic [15:0] addr;
    logic        tc;
    logic        mark;
    logic        rd;
    logic        wr;
    logic        wr_s1;
  } xfer_t;

  xfer_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: S1 negedge captures dack/address/tc/mark, S2 negedge captures strobes
  logic  in_xfer = 1'b0;
  logic [3:0] prev_dack = 4'b0000;
  xfer_t cap;
  always @(negedge clk) begin
    if (in_xfer) begin
      cap.rd  = ~memr_n;
      cap.wr  = ~memw_n;
      in_xfer = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected transfer: got %h expected none", cap);
      end else begin
        chk("transfer", 32'(cap), 32'(exp_q.pop_front()));
      end
    end else if (dack != 4'b0000 && prev_dack == 4'b0000) begin
      cap       = '0;
      cap.dack  = dack;
      cap.addr  = oaddr;
      cap.tc    = tc;
      cap.mark  = mark;
      cap.wr_s1 = ~memw_n;
      in_xfer   = 1'b1;
    end
    prev_dack = dack;
  end

  task automatic put(input logic [3:0] d, input logic [15:0] a, input logic t,
                     input logic m, input logic r, input logic w, input logic ws);
    xfer_t x;
    x.dack = d; x.addr = a; x.tc = t; x.mark = m; x.rd = r; x.wr = w; x.wr_s1 = ws;
    exp_q.push_back(x);
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk); iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr16(input logic [3:0] a, input logic [15:0] d);
    cpu_wr(a, d[7:0]);
    cpu_wr(a, d[15:8]);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); iaddr = a; ird_n = 1'b0;
    @(negedge clk); d = odata; ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd16(input logic [3:0] a, output logic [15:0] d);
    logic [7:0] lo, hi;
    cpu_rd(a, lo);
    cpu_rd(a, hi);
    d = {hi, lo};
  endtask

  task automatic do_reset();
    drq = 4'b0000;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_dack(input int budget);
    int n = 0;
    while (dack == 4'b0000 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dack seen", 32'(dack != 4'b0000), 32'd1);
  endtask

  task automatic settle(input string name);
    repeat (4) @(negedge clk);
    chk(name, 32'(hrq), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [15:0] w;
    reset = 1'b1; ce = 1'b1; iwe_n = 1'b1; ird_n = 1'b1; hlda = 1'b0;
    iaddr = 4'd0; idata = 8'h00; drq = 4'b0000;
    do_reset();
    chk("reset outputs", {hrq, dack, memr_n, memw_n, tc, mark, oaddr},
        {1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
    cpu_rd(4'd8, b);
    chk("reset status", b, 8'h00);

    // 80-transfer block on channel 0, tc on the last one
    wr16(4'd0, 16'hE000);
    wr16(4'd1, 16'h404F);
    cpu_wr(4'd8, 8'h01);
    hlda = 1'b1;
    for (int i = 0; i < 80; i++) put(4'b0001, 16'hE000 + 16'(i), i == 79, 1'b0, 1'b0, 1'b1, 1'b0);
    drq = 4'b0001;
    drain("block drain", 1000);
    drq = 4'b0000;
    settle("block idle");
    rd16(4'd0, w);
    chk("block end addr", w, 16'hE050);
    rd16(4'd1, w);
    chk("block end count", w, 16'h7FFF);
    cpu_rd(4'd8, b);
    chk("block status", b, 8'h01);
    cpu_rd(4'd8, b);
    chk("block status cleared", b, 8'h00);

    // Fixed priority: ch1 beats ch2 while it keeps requesting
    do_reset();
    wr16(4'd2, 16'h3000);
    wr16(4'd3, 16'h4010);
    wr16(4'd4, 16'h4000);
    wr16(4'd5, 16'h8010);
    cpu_wr(4'd8, 8'h06);
    put(4'b0010, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    put(4'b0010, 16'h3001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drq = 4'b0110;
    drain("fixed ch1 drain", 100);
    put(4'b0100, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drq = 4'b0100;
    drain("fixed ch2 drain", 100);
    drq = 4'b0000;
    settle("fixed idle");

    // Rotating priority with a mark on ch2 (count 0x80)
    do_reset();
    wr16(4'd2, 16'h3100);
    wr16(4'd3, 16'h4010);
    wr16(4'd4, 16'h4100);
    wr16(4'd5, 16'h8080);
    cpu_wr(4'd8, 8'h16);
    put(4'b0010, 16'h3100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    put(4'b0100, 16'h4100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    put(4'b0010, 16'h3101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drq = 4'b0110;
    drain("rotate drain", 100);
    drq = 4'b0000;
    settle("rotate idle");

    // TC-stop: channel disables itself even with drq held
    do_reset();
    wr16(4'd0, 16'h2000);
    wr16(4'd1, 16'h8002);
    cpu_wr(4'd8, 8'h41);
    put(4'b0001, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    put(4'b0001, 16'h2001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    put(4'b0001, 16'h2002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drq = 4'b0001;
    drain("tcstop drain", 100);
    settle("tcstop hrq with drq held");
    cpu_rd(4'd8, b);
    chk("tcstop status", b, 8'h01);
    cpu_rd(4'd8, b);
    chk("tcstop status cleared", b, 8'h00);
    drq = 4'b0000;

    // Extended write: memw asserted already in S1
    do_reset();
    wr16(4'd6, 16'h6000);
    wr16(4'd7, 16'h4003);
    cpu_wr(4'd8, 8'h28);
    put(4'b1000, 16'h6000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drq = 4'b1000;
    drain("extwr drain", 100);
    drq = 4'b0000;
    settle("extwr idle");

    // Autoload on channel 2
    do_reset();
    cpu_wr(4'd8, 8'h80);
    wr16(4'd4, 16'h5000);
    wr16(4'd5, 16'h8001);
    cpu_wr(4'd8, 8'h84);
    put(4'b0100, 16'h5000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    put(4'b0100, 16'h5001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drq = 4'b0100;
    drain("autoload drain", 100);
    drq = 4'b0000;
    settle("autoload idle");
`ifdef K580VT57_AUTOLOAD_EN
    cpu_rd(4'd8, b);
    chk("autoload status", b, 8'h14);
    cpu_rd(4'd8, b);
    chk("autoload update held", b, 8'h10);
    rd16(4'd4, w);
    chk("autoload ch2 addr", w, 16'h5000);
    rd16(4'd5, w);
    chk("autoload ch2 count", w, 16'h8001);
    rd16(4'd6, w);
    chk("autoload ch3 mirror", w, 16'h5000);
`else
    cpu_rd(4'd8, b);
    chk("noautoload status", b, 8'h04);
    cpu_rd(4'd8, b);
    chk("noautoload status cleared", b, 8'h00);
    rd16(4'd4, w);
    chk("noautoload ch2 addr", w, 16'h5002);
    rd16(4'd5, w);
    chk("noautoload ch2 count", w, 16'hBFFF);
`endif

    // Bus loss during S2: S4 still updates, then IDLE
    do_reset();
    wr16(4'd0, 16'h1000);
    wr16(4'd1, 16'h8005);
    cpu_wr(4'd8, 8'h01);
    hlda = 1'b1;
    put(4'b0001, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drq = 4'b0001;
    wait_dack(50);
    @(negedge clk);
    hlda = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("busloss idle", {hrq, dack, memr_n, memw_n}, {1'b0, 4'b0000, 1'b1, 1'b1});
    drq = 4'b0000;
    drain("busloss drain", 10);
    rd16(4'd0, w);
    chk("busloss addr", w, 16'h1001);
    rd16(4'd1, w);
    chk("busloss count", w, 16'h8004);

    // Reset keeps channel registers and aborts a transfer immediately
    do_reset();
    rd16(4'd0, w);
    chk("reset keeps addr", w, 16'h1001);
    rd16(4'd1, w);
    chk("reset keeps count", w, 16'h8004);
    cpu_wr(4'd8, 8'h01);
    hlda = 1'b1;
    put(4'b0001, 16'h1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drq = 4'b0001;
    wait_dack(50);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset outputs", {hrq, dack, memr_n, oaddr}, {1'b0, 4'b0000, 1'b1, 16'h0000});
    @(negedge clk);
    reset = 1'b0;
    drq = 4'b0000;
    drain("midreset drain", 10);
    rd16(4'd0, w);
    chk("midreset addr", w, 16'h1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
